miriscv_div_seq: RTL and testbench
==================================

MIRISCV_DIV_SEQ -- requirements
Module: miriscv_div_seq

Interface
REQ-001 clk_i  input  1  core clock; all state updates on rising edge.
REQ-002 arstn_i  input  1  reset, asynchronous, active-low.
REQ-003 div_req_i  input  1  divide request from execute stage (already qualified by decode valid); held stable with operands while div_stall_req_o=1.
REQ-004 div_op_i  input  2  operation: 2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU.
REQ-005 div_port_a_i  input  XLEN  dividend.
REQ-006 div_port_b_i  input  XLEN  divisor.
REQ-007 div_kill_i  input  1  abort current operation (pipeline flush).
REQ-008 div_keep_i  input  1  hold completed result; no new operation accepted.
REQ-009 div_result_o  output  XLEN  quotient or remainder, valid while state=DONE.
REQ-010 div_stall_req_o  output  1  execute stall request; combinational.
REQ-011 div_busy_o  output  1  high in CALC state.

Function
REQ-012 FSM states: IDLE, CALC, DONE; unsigned restoring division on operand magnitudes, one quotient bit per cycle.
REQ-013 IDLE & div_req_i & ~div_kill_i: capture magnitudes, signs, op; iteration counter := 0; go CALC; div_stall_req_o=1 in this cycle.
REQ-014 CALC: one iteration per cycle, counter +1; after iteration XLEN-1 (counter=XLEN-1) go DONE; div_stall_req_o=1 throughout.
REQ-015 Latency without early-out: request cycle 0, CALC cycles 1..XLEN, DONE cycle XLEN+1; stall high XLEN+1 cycles.
REQ-016 DONE: div_stall_req_o=0; div_result_o valid; next state IDLE unless div_keep_i=1 (stay DONE, result stable).
REQ-017 DONE & div_req_i on next cycle after leaving DONE starts a new operation per REQ-013 (back-to-back allowed, one idle cycle minimum).
REQ-018 Sign correction: DIV quotient negated iff signs differ; REM remainder takes dividend sign; DIVU/REMU unsigned.
REQ-019 Divisor zero: quotient = all ones, remainder = dividend, regardless of sign.
REQ-020 Overflow DIV/REM with a=0x8000_0000, b=0xFFFF_FFFF: quotient 0x8000_0000, remainder 0.
REQ-021 div_kill_i in any state: next state IDLE, div_stall_req_o=0 in that cycle, result discarded; kill wins over simultaneous req/keep.
REQ-022 div_req_i deasserted in CALC without kill: operation completes; result discarded on return to IDLE.
REQ-023 div_result_o = 0 outside DONE.

Reset
REQ-024 arstn_i low: state IDLE, counter 0, operand/partial-remainder/quotient registers 0, div_result_o=0, div_stall_req_o=0, div_busy_o=0.
REQ-025 Reset mid-CALC aborts immediately; first post-reset request behaves per REQ-013.

Configuration
REQ-026 Macro MIRISCV_DIV_EARLY_OUT_EN defined: IDLE request with divisor zero or |a|<|b| (unsigned magnitudes per op) goes directly to DONE; stall high 1 cycle; result per REQ-018/019.
REQ-027 Macro undefined: all requests take full REQ-015 latency; results identical.

Verification
REQ-028 DIVU a=100, b=7 -> stall 33 cycles, DONE result 14; REMU same -> 2.
REQ-029 DIV a=-7 (0xFFFF_FFF9), b=2 -> 0xFFFF_FFFD; REM -> 0xFFFF_FFFF.
REQ-030 DIV a=5, b=0 -> 0xFFFF_FFFF; REM -> 5; with MIRISCV_DIV_EARLY_OUT_EN stall exactly 1 cycle, else 33.
REQ-031 DIV a=0x8000_0000, b=0xFFFF_FFFF -> 0x8000_0000; REM -> 0.
REQ-032 div_kill_i at CALC cycle 10 -> stall 0 same cycle, IDLE next; following DIVU 9/3 -> 3 with full latency.
REQ-033 div_keep_i=1 for 3 cycles in DONE -> result held 4 cycles, stall 0; arstn_i pulse mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/miriscv_div_seq_if.sv
// Divider port bundle between the execute stage and miriscv_div_seq.
// The execute stage drives the master side; the divider is the slave.
interface miriscv_div_seq_if #(
    parameter int XLEN = 32
);
    logic            div_req_i;
    logic [1:0]      div_op_i;
    logic [XLEN-1:0] div_port_a_i;
    logic [XLEN-1:0] div_port_b_i;
    logic            div_kill_i;
    logic            div_keep_i;
    logic [XLEN-1:0] div_result_o;
    logic            div_stall_req_o;
    logic            div_busy_o;

    modport master (
        output div_req_i,
        output div_op_i,
        output div_port_a_i,
        output div_port_b_i,
        output div_kill_i,
        output div_keep_i,
        input  div_result_o,
        input  div_stall_req_o,
        input  div_busy_o
    );

    modport slave (
        input  div_req_i,
        input  div_op_i,
        input  div_port_a_i,
        input  div_port_b_i,
        input  div_kill_i,
        input  div_keep_i,
        output div_result_o,
        output div_stall_req_o,
        output div_busy_o
    );
endinterface

// File: rtl/miriscv_div_seq.sv
// Sequential restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define MIRISCV_DIV_EARLY_OUT_EN to finish divide-by-zero and |a|<|b| in one cycle.
module miriscv_div_seq #(
    parameter int XLEN = 32
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    miriscv_div_seq_if.slave div_if
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            isrem_q, isrem_d;

    logic            sgn;
    logic            a_neg;
    logic            b_neg;
    logic            b_zero;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            early;
    logic [XLEN:0]   tmp;
    logic [XLEN:0]   diff;
    logic            stall;
    logic [XLEN-1:0] res;

    assign sgn    = ~div_if.div_op_i[0];
    assign a_neg  = sgn & div_if.div_port_a_i[XLEN-1];
    assign b_neg  = sgn & div_if.div_port_b_i[XLEN-1];
    assign b_zero = (div_if.div_port_b_i == '0);
    assign a_mag  = a_neg ? (~div_if.div_port_a_i + 1'b1)
                          : div_if.div_port_a_i;
    assign b_mag  = b_neg ? (~div_if.div_port_b_i + 1'b1)
                          : div_if.div_port_b_i;

`ifdef MIRISCV_DIV_EARLY_OUT_EN
    assign early = b_zero | (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // Restoring step: quotient shares the shift register with the dividend.
    assign tmp  = {rem_q, quo_q[XLEN-1]};
    assign diff = tmp - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        isrem_d = isrem_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (div_if.div_req_i && !div_if.div_kill_i) begin
                    stall   = 1'b1;
                    cnt_d   = '0;
                    dvs_d   = b_mag;
                    quo_d   = a_mag;
                    rem_d   = '0;
                    qneg_d  = (a_neg ^ b_neg) & ~b_zero;
                    rneg_d  = a_neg;
                    isrem_d = div_if.div_op_i[1];
                    if (early) begin
                        state_d = DONE;
                        quo_d   = b_zero ? '1 : '0;
                        rem_d   = a_mag;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (div_if.div_kill_i) begin
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (!diff[XLEN]) begin
                        rem_d = diff[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = tmp[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (div_if.div_kill_i || !div_if.div_keep_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            isrem_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            isrem_q <= isrem_d;
        end
    end

    always_comb begin
        res = '0;
        if (isrem_q) begin
            res = rneg_q ? (~rem_q + 1'b1) : rem_q;
        end else begin
            res = qneg_q ? (~quo_q + 1'b1) : quo_q;
        end
    end

    // Request held high during reset must not leak through as a stall.
    assign div_if.div_stall_req_o = stall & arstn_i;
    assign div_if.div_busy_o      = (state_q == CALC);
    assign div_if.div_result_o    = (state_q == DONE) ? res : '0;
endmodule

// File: tb/tb_miriscv_div_seq.sv
// Scoreboard bench for miriscv_div_seq: driver queues expectations,
// a negedge monitor pops and compares at each completed division.
module tb_miriscv_div_seq;
    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

`ifdef MIRISCV_DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    logic clk;
    logic arstn;
    int   nvec;
    int   nbad;
    exp_t sb[$];

    miriscv_div_seq_if #(.XLEN(32)) dif ();

    miriscv_div_seq #(.XLEN(32)) dut (
        .clk_i  (clk),
        .arstn_i(arstn),
        .div_if (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    int          cnt;
    logic [31:0] held;
    logic        prev_keep;
    logic        prev_kill;
    logic        prev_done;
    logic        done_now;
    exp_t        e;

    initial begin
        cnt       = 0;
        held      = '0;
        prev_keep = 1'b0;
        prev_kill = 1'b0;
        prev_done = 1'b0;
    end

    always @(negedge clk) begin
        done_now = 1'b0;
        if (!arstn) begin
            chk("reset_out", {dif.div_result_o[29:0], dif.div_stall_req_o,
                dif.div_busy_o}, 32'h0);
            cnt = 0;
        end else if (dif.div_kill_i) begin
            chk("kill_stall", {31'h0, dif.div_stall_req_o}, 32'h0);
            cnt = 0;
        end else if (dif.div_stall_req_o) begin
            cnt++;
        end else if (cnt > 0) begin
            if (sb.size() == 0) begin
                nvec++;
                nbad++;
                $display("FAIL unexpected_done: got %h want none",
                         dif.div_result_o);
            end else begin
                e = sb.pop_front();
                chk("result", dif.div_result_o, e.res);
                chk("stall_len", cnt, e.lat);
                held = e.res;
            end
            done_now = 1'b1;
            cnt = 0;
        end else if (prev_keep) begin
            chk("keep_hold", dif.div_result_o, held);
            done_now = 1'b1;
        end else if (prev_done) begin
            chk("idle_zero", dif.div_result_o, 32'h0);
        end
        if (prev_kill && !dif.div_kill_i && arstn) begin
            chk("kill_idle", {31'h0, dif.div_busy_o}, 32'h0);
        end
        prev_keep = dif.div_keep_i;
        prev_kill = dif.div_kill_i;
        prev_done = done_now & ~dif.div_keep_i;
    end

    task automatic run(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input bit eo, input int keepn);
        bit   fin;
        exp_t x;
        @(posedge clk);
        #1;
        dif.div_req_i    = 1'b1;
        dif.div_op_i     = op;
        dif.div_port_a_i = a;
        dif.div_port_b_i = b;
        x.res = exp;
        x.lat = eo ? EO_LAT : 33;
        sb.push_back(x);
        fin = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (!dif.div_stall_req_o) begin
                fin = 1'b1;
                break;
            end
        end
        if (!fin) begin
            nvec++;
            nbad++;
            $display("FAIL timeout: got stall=1 want stall=0");
        end
        dif.div_req_i  = 1'b0;
        dif.div_keep_i = (keepn > 0);
        repeat (keepn) begin
            @(posedge clk);
            #1;
        end
        dif.div_keep_i = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nbad = 0;
        arstn = 1'b0;
        dif.div_req_i    = 1'b0;
        dif.div_op_i     = 2'b00;
        dif.div_port_a_i = '0;
        dif.div_port_b_i = '0;
        dif.div_kill_i   = 1'b0;
        dif.div_keep_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arstn = 1'b1;

        run(2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 3);
        run(2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 0);
        run(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 0);
        run(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 0);
        run(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
        run(2'b10, 32'd5, 32'd0, 32'd5, 1'b1, 0);
        run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
        run(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 0);
        run(2'b11, 32'hFFFF_FFFF, 32'd16, 32'hF, 1'b0, 0);
        run(2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0, 0);
        run(2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 0);
        run(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 0);
        run(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 0);
        run(2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);
        run(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1, 0);
        run(2'b01, 32'd3, 32'd5, 32'd0, 1'b1, 0);
        run(2'b11, 32'd3, 32'd5, 32'd3, 1'b1, 0);
        run(2'b01, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1'b1, 0);

        // Flush at CALC cycle 10, then a clean DIVU.
        @(posedge clk);
        #1;
        dif.div_req_i    = 1'b1;
        dif.div_op_i     = 2'b01;
        dif.div_port_a_i = 32'd1000;
        dif.div_port_b_i = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        dif.div_kill_i = 1'b1;
        @(posedge clk);
        #1;
        dif.div_kill_i = 1'b0;
        dif.div_req_i  = 1'b0;
        run(2'b01, 32'd9, 32'd3, 32'd3, 1'b0, 0);

        // Asynchronous reset in the middle of a division.
        @(posedge clk);
        #1;
        dif.div_req_i    = 1'b1;
        dif.div_op_i     = 2'b01;
        dif.div_port_a_i = 32'd500;
        dif.div_port_b_i = 32'd9;
        repeat (5) @(posedge clk);
        #3;
        arstn = 1'b0;
        @(posedge clk);
        #1;
        dif.div_req_i = 1'b0;
        arstn = 1'b1;
        run(2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 0);

        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            nvec++;
            nbad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
